inst_fetch: RTL and testbench

Parametrised instruction-fetch unit replacing the single-cycle `pc_reg`/`if_id` pair at the front of the five-stage RISC-V pipeline. It issues in-order requests to a variable-latency instruction memory, buffers up to `DEPTH` fetched instructions with their PCs, and presents them to ID through a valid/ready handshake. Jump redirects from ID flush the buffer and discard in-flight responses.

---
 rtl/riscv_defs.sv | 16 +
 rtl/fetch_fifo.sv | 87 ++++++++
 rtl/inst_fetch.sv | 139 +++++++++++++
 tb/tb_inst_fetch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// -----------------------------------------------------------------------------
// riscv_defs
//   Shared definitions for the front end of the five-stage RISC-V pipeline.
//   XLEN         : architectural register / address width
//   InstAddrBus  : width of an instruction address
//   InstBus      : width of an instruction word
//   PC_STEP      : byte distance between consecutive sequential fetches
// -----------------------------------------------------------------------------
package riscv_defs;

  localparam int XLEN        = 32;
  localparam int InstAddrBus = XLEN;
  localparam int InstBus     = XLEN;
  localparam int PC_STEP     = 4;

endpackage : riscv_defs

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO holding fetched {pc, inst} entries between the
//   instruction-memory response path and the ID stage.
//
//   Parameters : WIDTH (entry width), DEPTH (entries, power of two, >= 2)
//   Ports      :
//     clk      in          clock
//     rst      in          synchronous active-high reset
//     clear_i  in          drop every entry; beats push/pop in the same cycle
//     push_i   in          write data_i at the tail
//     data_i   in  WIDTH   entry to write
//     pop_i    in          advance the head (ignored when empty)
//     data_o   out WIDTH   head entry, forced to 0 while empty
//     count_o  out CW      registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  // NOTE: every always_comb output gets a default on entry so no path
  // through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    do_push  = push_i && !clear_i;
    do_pop   = pop_i && (count_q != '0) && !clear_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array carries no reset; an entry is only observable
  // after it has been written, and the empty case is masked on data_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule : fetch_fifo

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch unit for the five-stage RISC-V pipeline. Issues in-order
//   requests to a variable-latency instruction memory, buffers up to DEPTH
//   fetched {pc, inst} entries and hands them to ID over valid/ready. A jump
//   from ID flushes the buffer and discards responses still in flight.
//
//   Parameters : XLEN, DEPTH (power of two, >= 2), RESET_PC (bits [1:0] ignored)
//   Ports      :
//     clk          in          clock
//     rst          in          synchronous active-high reset (shared with memory)
//     rom_addr_o   out XLEN    request address, word aligned
//     rom_ce_o     out         request valid
//     rom_ready_i  in          memory accepts the request this cycle
//     rom_valid_i  in          in-order response valid
//     rom_data_i   in  XLEN    response instruction
//     jump_i       in          redirect from ID
//     jump_addr_i  in  XLEN    redirect target
//     id_valid_o   out         head entry valid
//     id_pc_o      out XLEN    head PC
//     id_inst_o    out XLEN    head instruction
//     id_ready_i   in          ID consumes the head
// -----------------------------------------------------------------------------
module inst_fetch
  import riscv_defs::*;
#(
  parameter int              XLEN     = riscv_defs::InstAddrBus,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] rom_addr_o,
  output logic            rom_ce_o,
  input  logic            rom_ready_i,
  input  logic            rom_valid_i,
  input  logic [XLEN-1:0] rom_data_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_inst_o,
  input  logic            id_ready_i
);

  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] RESET_PC_W = {RESET_PC[XLEN-1:2], 2'b00};
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q,  resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic              credit;
  logic              req_fire;
  logic              resp_fire;
  logic              push;
  logic              pop;
  logic [XLEN-1:0]   jump_target;
  logic [2*XLEN-1:0] head;
  logic              unused_jump_lsbs;

  assign jump_target      = {jump_addr_i[XLEN-1:2], 2'b00};
  assign unused_jump_lsbs = ^jump_addr_i[1:0];

  // Credit: a request is only issued if the buffer is guaranteed a slot for
  // its response, so a push can never meet a full queue. One extra bit keeps
  // the sum from overflowing.
  assign occupancy = {1'b0, count} + {1'b0, inflight_q};
  assign credit    = occupancy < (CW+1)'(DEPTH);

  assign rom_ce_o   = !rst && !jump_i && credit;
  assign rom_addr_o = fetch_pc_q;

  assign req_fire   = rom_ce_o && rom_ready_i;
  // Responses with nothing outstanding are stray and ignored.
  assign resp_fire  = rom_valid_i && (inflight_q != '0);
  // Kept responses are the ones not owed to an earlier redirect; a response
  // landing in a jump cycle belongs to the old stream and is dropped too.
  assign push       = resp_fire && (drop_cnt_q == '0) && !jump_i;

  assign id_valid_o = (count != '0);
  assign pop        = id_valid_o && id_ready_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_cnt_d = drop_cnt_q;

    inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);

    if (jump_i) begin
      fetch_pc_d = jump_target;
      resp_pc_d  = jump_target;
      // Everything still outstanding after this cycle belongs to the old
      // stream; recomputed from scratch on each of back-to-back jumps.
      drop_cnt_d = inflight_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
      if (push)     resp_pc_d  = resp_pc_q + STEP;
      if (resp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC_W;
      resp_pc_q  <= RESET_PC_W;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (jump_i),
    .push_i  (push),
    .data_i  ({resp_pc_q, rom_data_i}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

  assign id_pc_o   = head[2*XLEN-1:XLEN];
  assign id_inst_o = head[XLEN-1:0];

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Self-checking bench for inst_fetch. A behavioural instruction memory with
//   configurable ready probability and in-order latency answers requests; every
//   accepted request pushes its expected {pc, inst} to a scoreboard that is
//   popped and compared whenever ID consumes an entry. Redirects flush the
//   scoreboard, reset clears scoreboard and memory.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] rom_addr_o;
  logic            rom_ce_o;
  logic            rom_ready_i;
  logic            rom_valid_i;
  logic [XLEN-1:0] rom_data_i;
  logic            jump_i;
  logic [XLEN-1:0] jump_addr_i;
  logic            id_valid_o;
  logic [XLEN-1:0] id_pc_o;
  logic [XLEN-1:0] id_inst_o;
  logic            id_ready_i;

  inst_fetch #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr_o  (rom_addr_o),
    .rom_ce_o    (rom_ce_o),
    .rom_ready_i (rom_ready_i),
    .rom_valid_i (rom_valid_i),
    .rom_data_i  (rom_data_i),
    .jump_i      (jump_i),
    .jump_addr_i (jump_addr_i),
    .id_valid_o  (id_valid_o),
    .id_pc_o     (id_pc_o),
    .id_inst_o   (id_inst_o),
    .id_ready_i  (id_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } mem_req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  mem_req_t    mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus knobs, applied by step().
  int          k_lo = 1, k_hi = 1;
  int          rdy_pct = 100, idr_pct = 100;
  logic        rst_in = 1'b1, jump_in = 1'b0, stray_in = 1'b0;
  logic [31:0] jaddr_in = '0;

  int          cyc = 0;
  int          last_due = 0;
  int          n_pop = 0;
  logic [31:0] exp_fetch_pc = RESET_PC;
  int          exp_drop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: drive inputs after the falling edge, observe 1 time unit later,
  // then the next rising edge commits the cycle.
  task automatic step();
    bit       resp;
    exp_t     e;
    int       k;
    int       due;
    @(negedge clk);
    rst         = rst_in;
    jump_i      = jump_in;
    jump_addr_i = jaddr_in;
    rom_ready_i = ($urandom_range(99) < rdy_pct);
    id_ready_i  = ($urandom_range(99) < idr_pct);
    resp        = 1'b0;
    rom_valid_i = 1'b0;
    rom_data_i  = '0;
    if (stray_in) begin
      rom_valid_i = 1'b1;
      rom_data_i  = 32'hDEAD_BEEF;
    end else if (!rst_in && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      rom_valid_i = 1'b1;
      rom_data_i  = mem_q[0].data;
      resp        = 1'b1;
    end
    #1;
    if (rst_in) begin
      check("ce_in_reset", rom_ce_o, 0);
      mem_q.delete();
      exp_q.delete();
      exp_fetch_pc = RESET_PC;
      last_due     = 0;
    end else begin
      if (id_valid_o && id_ready_i && !jump_in) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("id_pc", id_pc_o, e.pc);
          check("id_inst", id_inst_o, e.inst);
        end
        n_pop++;
        pop_log.push_back(id_pc_o);
      end
      if (rom_ce_o && rom_ready_i) begin
        check("req_addr", rom_addr_o, exp_fetch_pc);
        req_log.push_back(rom_addr_o);
        exp_q.push_back('{exp_fetch_pc, word_of(exp_fetch_pc)});
        k   = $urandom_range(k_hi, k_lo);
        due = cyc + k;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{rom_addr_o, word_of(rom_addr_o), due});
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      if (jump_in) begin
        check("ce_in_jump", rom_ce_o, 0);
        exp_q.delete();
        exp_fetch_pc = {jaddr_in[31:2], 2'b00};
      end
      if (resp) void'(mem_q.pop_front());
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    jump_i      = 1'b0;
    jump_addr_i = '0;
    rom_ready_i = 1'b0;
    rom_valid_i = 1'b0;
    rom_data_i  = '0;
    id_ready_i  = 1'b0;

    // Reset release, k=1, everything ready: 2-cycle fill then 1/cycle.
    k_lo = 1; k_hi = 1; rdy_pct = 100; idr_pct = 100;
    do_reset();
    step();
    check("t1_valid_c0", id_valid_o, 0);
    check("t1_pc_c0", id_pc_o, 0);
    check("t1_inst_c0", id_inst_o, 0);
    check("t1_addr_c0", rom_addr_o, RESET_PC);
    check("t1_ce_c0", rom_ce_o, 1);
    step();
    check("t1_valid_c1", id_valid_o, 0);
    step();
    check("t1_valid_c2", id_valid_o, 1);
    check("t1_pc_c2", id_pc_o, RESET_PC);
    n_pop = 0;
    repeat (16) step();
    check("t1_rate", n_pop, 16);

    // ID stalled: exactly DEPTH requests, then resume at 0x110.
    do_reset();
    idr_pct = 0;
    req_log.delete();
    repeat (10) step();
    check("t2_nreq", req_log.size(), DEPTH);
    check("t2_ce_off", rom_ce_o, 0);
    check("t2_valid", id_valid_o, 1);
    check("t2_head_pc", id_pc_o, RESET_PC);
    check("t2_head_inst", id_inst_o, word_of(RESET_PC));
    idr_pct = 100;
    req_log.delete();
    for (int i = 0; i < 6 && req_log.size() == 0; i++) step();
    check("t2_resume_seen", req_log.size() != 0, 1);
    if (req_log.size() != 0) check("t2_resume_addr", req_log[0], 32'h110);
    repeat (20) step();

    // k=3 with three requests outstanding, jump to 0x203.
    do_reset();
    k_lo = 3; k_hi = 3;
    repeat (3) step();
    check("t3_nothing_back", id_valid_o, 0);
    jump_in = 1'b1; jaddr_in = 32'h203;
    req_log.delete();
    pop_log.delete();
    step();
    jump_in = 1'b0;
    for (int i = 0; i < 6 && req_log.size() == 0; i++) step();
    check("t3_req_seen", req_log.size() != 0, 1);
    if (req_log.size() != 0) check("t3_req_addr", req_log[0], 32'h200);
    repeat (15) step();
    check("t3_pop_seen", pop_log.size() != 0, 1);
    if (pop_log.size() != 0) check("t3_first_pc", pop_log[0], 32'h200);

    // Jump coinciding with a response and a consumed head.
    do_reset();
    k_lo = 2; k_hi = 2;
    repeat (6) step();
    jump_in = 1'b1; jaddr_in = 32'h400;
    step();
    check("t4_setup_valid", id_valid_o, 1);
    check("t4_setup_resp", rom_valid_i, 1);
    exp_drop = mem_q.size();
    jump_in  = 1'b0;
    step();
    check("t4_empty", id_valid_o, 0);
    check("t4_drop_cnt", dut.drop_cnt_q, exp_drop);
    check("t4_ce", rom_ce_o, 1);
    check("t4_target", rom_addr_o, 32'h400);
    repeat (10) step();

    // Random ready / latency, occasional redirects, 1000 instructions.
    do_reset();
    k_lo = 1; k_hi = 5; rdy_pct = 70; idr_pct = 70;
    n_pop = 0;
    for (int i = 0; i < 20000 && n_pop < 1000; i++) begin
      jump_in  = ($urandom_range(199) == 0);
      jaddr_in = $urandom;
      step();
      jump_in = 1'b0;
    end
    check("t5_count", n_pop >= 1000, 1);

    // Reset with entries buffered and requests outstanding, then stray pulses.
    do_reset();
    k_lo = 3; k_hi = 3; rdy_pct = 100; idr_pct = 0;
    repeat (5) step();
    check("t6_loaded", id_valid_o, 1);
    rst_in = 1'b1;
    step();
    rst_in  = 1'b0;
    rdy_pct = 0;
    step();
    check("t6_valid", id_valid_o, 0);
    check("t6_pc", id_pc_o, 0);
    check("t6_inst", id_inst_o, 0);
    check("t6_addr", rom_addr_o, RESET_PC);
    stray_in = 1'b1;
    idr_pct  = 100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_stray_valid", id_valid_o, 0);
    end
    stray_in = 1'b0;
    repeat (2) step();
    check("t6_no_entry", id_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_inst_fetch
